second_layer_tnndirect: RTL and testbench

- Output layer of the ternary direct classifier; consumes the binary hidden vector from the first layer once that layer's level-high done is asserted.
- Walks the hidden bits serially, one per cycle, and accumulates a signed score for every class using compile-time ternary weights.
- Then scans the scores serially, emits the argmax class index and holds it with valid.

---
 rtl/second_layer_tnndirect.sv | 168 ++++++++++++++++
 tb/tb_second_layer_tnndirect.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/second_layer_tnndirect.sv
`default_nettype none
// ============================================================================
// Module   : second_layer_tnndirect
// Brief    : Ternary-weight output layer. It walks the latched hidden bits
//            serially to build per-class scores, then scans for the argmax.
// Revision : 1.0
// ============================================================================
module second_layer_tnndirect #(
    parameter int HIDDEN_CNT = 4,
    parameter int CLASS_CNT  = 3,
    parameter logic [2*HIDDEN_CNT*CLASS_CNT-1:0] WEIGHTS = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [HIDDEN_CNT-1:0]        hidden,
    input  logic                         start,
    output logic                         busy,
    output logic                         valid,
    output logic [$clog2(CLASS_CNT)-1:0] class_out
);

    localparam int SUM_BITS = $clog2(HIDDEN_CNT + 1) + 1;
    localparam int c_CLS_W  = $clog2(CLASS_CNT);
    localparam int c_IDX_W  = (HIDDEN_CNT > CLASS_CNT) ? $clog2(HIDDEN_CNT) : c_CLS_W;
    localparam logic [c_IDX_W-1:0]         c_H_LAST  = c_IDX_W'(HIDDEN_CNT - 1);
    localparam logic [c_IDX_W-1:0]         c_C_LAST  = c_IDX_W'(CLASS_CNT - 1);
    localparam logic [c_IDX_W-1:0]         c_IDX_ONE = c_IDX_W'(1);
    localparam logic signed [SUM_BITS-1:0] c_ONE     = SUM_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_ARG  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [HIDDEN_CNT-1:0]        r_hidden;
    logic [c_IDX_W-1:0]           r_idx;
    logic signed [SUM_BITS-1:0]   r_score [CLASS_CNT];
    logic signed [SUM_BITS-1:0]   r_best_val;
    logic [c_CLS_W-1:0]           r_best_idx;
    logic [c_CLS_W-1:0]           r_class;

    logic [HIDDEN_CNT-1:0][CLASS_CNT-1:0] w_pos;
    logic [HIDDEN_CNT-1:0][CLASS_CNT-1:0] w_neg;
    logic [CLASS_CNT-1:0]         w_pos_row;
    logic [CLASS_CNT-1:0]         w_neg_row;
    logic                         w_bit;
    logic signed [SUM_BITS-1:0]   w_score_nxt [CLASS_CNT];
    logic signed [SUM_BITS-1:0]   w_cur;
    logic                         w_take;
    logic signed [SUM_BITS-1:0]   w_best_val_nxt;
    logic [c_CLS_W-1:0]           w_best_idx_nxt;

    // Decode the ternary weight table into +1 / -1 flags; 2'b00 and 2'b10 are zero.
    for (genvar h = 0; h < HIDDEN_CNT; h++) begin : g_hid
        for (genvar c = 0; c < CLASS_CNT; c++) begin : g_cls
            assign w_pos[h][c] = (WEIGHTS[2*(h*CLASS_CNT+c) +: 2] == 2'b01);
            assign w_neg[h][c] = (WEIGHTS[2*(h*CLASS_CNT+c) +: 2] == 2'b11);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        valid  = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_ACC;
            S_ACC: begin
                busy = 1'b1;
                if (r_idx == c_H_LAST) w_next = S_ARG;
            end
            S_ARG: begin
                busy = 1'b1;
                if (r_idx == c_C_LAST) w_next = S_DONE;
            end
            S_DONE: begin
                valid = 1'b1;
                if (!start) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Activation is treated as +/-1: a zero bit subtracts the weight.
    always_comb begin
        w_bit     = 1'b0;
        w_pos_row = '0;
        w_neg_row = '0;
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            if (r_idx == c_IDX_W'(h)) begin
                w_bit     = r_hidden[h];
                w_pos_row = w_pos[h];
                w_neg_row = w_neg[h];
            end
        end
        for (int c = 0; c < CLASS_CNT; c++) begin
            w_score_nxt[c] = r_score[c];
            if ((w_pos_row[c] && w_bit) || (w_neg_row[c] && !w_bit)) begin
                w_score_nxt[c] = r_score[c] + c_ONE;
            end else if ((w_neg_row[c] && w_bit) || (w_pos_row[c] && !w_bit)) begin
                w_score_nxt[c] = r_score[c] - c_ONE;
            end
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        w_cur = '0;
        for (int c = 0; c < CLASS_CNT; c++) begin
            if (r_idx == c_IDX_W'(c)) w_cur = r_score[c];
        end
        w_take         = (r_idx == '0) || (w_cur > r_best_val);
        w_best_val_nxt = w_take ? w_cur : r_best_val;
        w_best_idx_nxt = w_take ? r_idx[c_CLS_W-1:0] : r_best_idx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hidden   <= '0;
            r_idx      <= '0;
            r_best_val <= '0;
            r_best_idx <= '0;
            r_class    <= '0;
            for (int c = 0; c < CLASS_CNT; c++) r_score[c] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_hidden <= hidden;
                        r_idx    <= '0;
                        for (int c = 0; c < CLASS_CNT; c++) r_score[c] <= '0;
                    end
                end
                S_ACC: begin
                    for (int c = 0; c < CLASS_CNT; c++) r_score[c] <= w_score_nxt[c];
                    r_idx <= (r_idx == c_H_LAST) ? '0 : r_idx + c_IDX_ONE;
                end
                S_ARG: begin
                    r_best_val <= w_best_val_nxt;
                    r_best_idx <= w_best_idx_nxt;
                    if (r_idx == c_C_LAST) begin
                        r_class <= w_best_idx_nxt;
                        r_idx   <= '0;
                    end else begin
                        r_idx   <= r_idx + c_IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign class_out = r_class;

endmodule
`default_nettype wire

// File: tb/tb_second_layer_tnndirect.sv
`default_nettype none
// ============================================================================
// Module   : tb_second_layer_tnndirect
// Brief    : Scoreboard bench for second_layer_tnndirect over three weight sets.
// Revision : 1.0
// ============================================================================
module tb_second_layer_tnndirect;

    // Set A: class0 all +1, class1 all -1, class2 +1 on h0 only.
    localparam logic [23:0] c_W_A = 24'b001101_001101_001101_011101;
    localparam logic [23:0] c_W_Z = 24'd0;
    // Set C: class0 all -1, class1 and class2 all +1.
    localparam logic [23:0] c_W_C = 24'b010111_010111_010111_010111;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hidden;
    logic       start;
    logic       busy_a, valid_a, busy_z, valid_z, busy_c, valid_c;
    logic [1:0] class_a, class_z, class_c;

    int n_vec = 0;
    int n_err = 0;
    int sb_a[$];
    int sb_z[$];
    int sb_c[$];

    always #5 clk = ~clk;

    second_layer_tnndirect #(.HIDDEN_CNT(4), .CLASS_CNT(3), .WEIGHTS(c_W_A)) dut_a (
        .clk(clk), .rst(rst), .hidden(hidden), .start(start),
        .busy(busy_a), .valid(valid_a), .class_out(class_a));
    second_layer_tnndirect #(.HIDDEN_CNT(4), .CLASS_CNT(3), .WEIGHTS(c_W_Z)) dut_z (
        .clk(clk), .rst(rst), .hidden(hidden), .start(start),
        .busy(busy_z), .valid(valid_z), .class_out(class_z));
    second_layer_tnndirect #(.HIDDEN_CNT(4), .CLASS_CNT(3), .WEIGHTS(c_W_C)) dut_c (
        .clk(clk), .rst(rst), .hidden(hidden), .start(start),
        .busy(busy_c), .valid(valid_c), .class_out(class_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input logic [23:0] w, input logic [3:0] h);
        int s[3];
        int best;
        logic [1:0] wt;
        int v;
        for (int c = 0; c < 3; c++) begin
            s[c] = 0;
            for (int k = 0; k < 4; k++) begin
                wt = w[2*(k*3+c) +: 2];
                v  = (wt == 2'b01) ? 1 : ((wt == 2'b11) ? -1 : 0);
                s[c] += h[k] ? v : -v;
            end
        end
        best = 0;
        for (int c = 1; c < 3; c++) if (s[c] > s[best]) best = c;
        return best;
    endfunction

    // Called at a negedge; returns at a negedge with start low and the DUTs in IDLE.
    task automatic do_run(input logic [3:0] h, input logic [3:0] h_after,
                          input bit drop, input int hold);
        int lat;
        int n_busy;
        int ea, ez, ec;
        hidden = h;
        start  = 1'b1;
        sb_a.push_back(model(c_W_A, h));
        sb_z.push_back(model(c_W_Z, h));
        sb_c.push_back(model(c_W_C, h));
        @(posedge clk);
        lat    = 0;
        n_busy = 0;
        @(negedge clk);
        hidden = h_after;
        if (drop) start = 1'b0;
        while (!valid_a && lat < 20) begin
            if (busy_a) n_busy++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("latency", lat, 7);
        check("busy_cycles", n_busy, 7);
        check("busy_with_valid", busy_a, 1'b0);
        ea = (sb_a.size() > 0) ? sb_a.pop_front() : -1;
        ez = (sb_z.size() > 0) ? sb_z.pop_front() : -1;
        ec = (sb_c.size() > 0) ? sb_c.pop_front() : -1;
        check("class_a", class_a, ea);
        check("class_z", class_z, ez);
        check("class_c", class_c, ec);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", valid_a, 1'b1);
            check("hold_busy", busy_a, 1'b0);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("valid_drop", valid_a, 1'b0);
        check("class_held", class_a, ea);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        hidden = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy_a, 1'b0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_class", class_a, 2'd0);
        rst = 1'b1;
        @(negedge clk);

        do_run(4'b1111, 4'b1111, 1'b0, 10);   // 4/-4/1 -> 0, then held 10 cycles
        do_run(4'b0000, 4'b0000, 1'b0, 0);    // -4/4/-1 -> 1
        do_run(4'b1111, 4'b0000, 1'b0, 0);    // input change after capture ignored -> 0
        do_run(4'b0011, 4'b0011, 1'b1, 0);    // 0/0/1 -> 2, start dropped during ACC

        // Reset in the second ACC cycle abandons the run.
        hidden = 4'b0000;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("mid_busy_before", busy_a, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_valid", valid_a, 1'b0);
        check("mid_rst_class", class_a, 2'd0);
        rst = 1'b1;
        do_run(4'b1111, 4'b1111, 1'b0, 0);

        check("sb_empty", sb_a.size() + sb_z.size() + sb_c.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
